// File: rtl/icache_block_fill_if.sv
// Fetch-side and main-memory-side signals of the single-block instruction buffer.
// slave = the buffer itself; master = fetch unit plus memory (or a testbench standing in for both).
interface icache_block_fill_if;
  logic [31:0] PC1;
  logic [31:0] PC2;
  logic        miss;
  logic [9:0]  BlockTag;
  logic [31:0] Instruction1i;
  logic [31:0] Instruction2i;
  logic        missback;
  logic [9:0]  BlockHere;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;

  modport slave (
    input  PC1, PC2, miss, BlockTag, MemAck, MemData,
    output Instruction1i, Instruction2i, missback, BlockHere, MemReq, MemAddr
  );

  modport master (
    output PC1, PC2, miss, BlockTag, MemAck, MemData,
    input  Instruction1i, Instruction2i, missback, BlockHere, MemReq, MemAddr
  );
endinterface

// File: rtl/icache_block_fill.sv
// One-block instruction buffer: two combinational reads per cycle, 32-word block fill over req/ack.
// Hit on resident tag answers missback after 1 cycle; a fill holds MemReq until each MemAck, then missback.
module icache_block_fill #(
  parameter int          BLOCK_WORDS = 32,
  parameter int          TAG_W       = 10,
  parameter logic [10:0] MISS_OPC    = 11'b00011111111
) (
  input logic              clk,
  input logic              reset,
  icache_block_fill_if.slave bus
);

  localparam int IDX_W   = $clog2(BLOCK_WORDS);
  localparam int TAG_LSB = IDX_W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RESP = 2'd2} state_t;

  state_t             state, state_nx;
  logic [31:0]        mem [BLOCK_WORDS];
  logic [TAG_W-1:0]   cur_tag, cur_tag_nx;
  logic               valid, valid_nx;
  logic [IDX_W-1:0]   fill_idx, fill_idx_nx;
  logic               mem_req, mem_req_nx;
  logic [31:0]        mem_addr, mem_addr_nx;
  logic               missback_q, missback_nx;
  logic [TAG_W-1:0]   block_here, block_here_nx;
  logic               tag_hit, beat, last_beat;
  logic               hit1, hit2;
  logic               unused_pc_bits;

  function automatic logic [31:0] word_addr(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx);
    return {{(30-TAG_W-IDX_W){1'b0}}, tag, idx, 2'b00};
  endfunction

  function automatic logic [31:0] miss_word(input logic [TAG_W-1:0] tag);
    return {MISS_OPC, tag, {(21-TAG_W){1'b0}}};
  endfunction

  assign tag_hit   = valid && (bus.BlockTag == cur_tag);
  // MemAck is only meaningful while a request is outstanding in FILL
  assign beat      = (state == FILL) && mem_req && bus.MemAck;
  assign last_beat = beat && (fill_idx == IDX_W'(BLOCK_WORDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.miss) state_nx = tag_hit ? RESP : FILL;
      FILL:    if (last_beat) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cur_tag_nx    = cur_tag;
    valid_nx      = valid;
    fill_idx_nx   = fill_idx;
    mem_req_nx    = mem_req;
    mem_addr_nx   = mem_addr;
    missback_nx   = 1'b0;
    block_here_nx = block_here;
    case (state)
      IDLE: begin
        if (bus.miss) begin
          if (tag_hit) begin
            missback_nx   = 1'b1;
            block_here_nx = cur_tag;
          end else begin
            cur_tag_nx  = bus.BlockTag;
            valid_nx    = 1'b0;
            fill_idx_nx = '0;
            mem_req_nx  = 1'b1;
            mem_addr_nx = word_addr(bus.BlockTag, '0);
          end
        end
      end
      FILL: begin
        // Next word is requested in the same cycle the current one is accepted
        if (beat) begin
          fill_idx_nx = fill_idx + 1'b1;
          mem_addr_nx = word_addr(cur_tag, fill_idx + 1'b1);
          if (last_beat) begin
            mem_req_nx    = 1'b0;
            valid_nx      = 1'b1;
            missback_nx   = 1'b1;
            block_here_nx = cur_tag;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_tag    <= '0;
      valid      <= 1'b0;
      fill_idx   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      missback_q <= 1'b0;
      block_here <= '0;
    end else begin
      cur_tag    <= cur_tag_nx;
      valid      <= valid_nx;
      fill_idx   <= fill_idx_nx;
      mem_req    <= mem_req_nx;
      mem_addr   <= mem_addr_nx;
      missback_q <= missback_nx;
      block_here <= block_here_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) mem[fill_idx] <= bus.MemData;
  end

  assign hit1 = valid && (state == IDLE) && (bus.PC1[TAG_LSB +: TAG_W] == cur_tag);
  assign hit2 = valid && (state == IDLE) && (bus.PC2[TAG_LSB +: TAG_W] == cur_tag);

  assign bus.Instruction1i = hit1 ? mem[bus.PC1[2 +: IDX_W]] : miss_word(bus.PC1[TAG_LSB +: TAG_W]);
  assign bus.Instruction2i = hit2 ? mem[bus.PC2[2 +: IDX_W]] : miss_word(bus.PC2[TAG_LSB +: TAG_W]);

  assign bus.missback  = missback_q;
  assign bus.BlockHere = block_here;
  assign bus.MemReq    = mem_req;
  assign bus.MemAddr   = mem_addr;

  assign unused_pc_bits = ^{bus.PC1[31:TAG_LSB+TAG_W], bus.PC1[1:0],
                            bus.PC2[31:TAG_LSB+TAG_W], bus.PC2[1:0]};

endmodule

// File: tb/tb_icache_block_fill.sv
// Directed sequence with randomized reads and memory timing, checked against a block-level model.
module tb_icache_block_fill;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  logic [31:0] seed;
  bit          model_valid;
  logic [9:0]  model_tag;

  icache_block_fill_if bus();

  icache_block_fill dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Main memory contents: a fixed scramble of the word address
  function automatic logic [31:0] memfun(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  // Expected fetch result: resident word if the block matches, else miss opcode + tag
  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    logic [31:0] tag;
    tag = (pc >> 7) & 32'h3FF;
    if (model_valid && tag == 32'(model_tag))
      return memfun(pc & 32'h0001_FFFC);
    return (32'h0FF << 21) | (tag << 11);
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic read2(input logic [31:0] pc1, input logic [31:0] pc2);
    @(negedge clk);
    bus.PC1 = pc1;
    bus.PC2 = pc2;
    #1;
    check("instr1", bus.Instruction1i, exp_instr(pc1));
    check("instr2", bus.Instruction2i, exp_instr(pc2));
  endtask

  // Idle cycles: random reads, stray MemAck/MemData that must be ignored
  task automatic rand_reads(input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.MemAck  = 1'($urandom_range(0, 1));
      bus.MemData = $urandom;
      pc = $urandom;
      if ($urandom_range(0, 1) == 1) pc = {pc[31:17], model_tag, pc[6:0]};
      bus.PC1 = pc;
      bus.PC2 = pc + 32'd4;
      #1;
      check("rand_instr1", bus.Instruction1i, exp_instr(pc));
      check("rand_instr2", bus.Instruction2i, exp_instr(pc + 32'd4));
      check("idle_memreq", 32'(bus.MemReq), 32'd0);
      check("idle_missback", 32'(bus.missback), 32'd0);
    end
    bus.MemAck = 1'b0;
  endtask

  // Acts as main memory for one fill; mode 0 zero-wait, 1 ack every 3rd cycle, 2 random
  task automatic fill_phase(input logic [9:0] tag, input int mode, input int start_beat,
                            input int stop_beat, output int req_cycles, output int beats);
    bit done;
    bit ack;
    done = 0;
    beats = start_beat;
    req_cycles = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      bus.MemAck = 1'b0;
      if (bus.missback === 1'b1) begin
        done = 1;
      end else begin
        check("req_held", 32'(bus.MemReq), 32'd1);
        if (bus.MemReq === 1'b1) begin
          req_cycles++;
          check("mem_addr", bus.MemAddr, 32'(tag) * 32'd128 + 32'(beats) * 32'd4);
          case (mode)
            0:       ack = 1;
            1:       ack = (req_cycles % 3 == 0);
            default: ack = ($urandom_range(0, 1) == 1);
          endcase
          bus.MemAck  = ack;
          bus.MemData = memfun(bus.MemAddr);
          if (ack) beats++;
          if (beats == stop_beat) done = 1;
        end
      end
    end
    check("fill_done", 32'(done), 32'd1);
  endtask

  task automatic do_fill(input logic [9:0] tag, input int mode, input int exp_req);
    int rc, b;
    bus.miss     = 1'b1;
    bus.BlockTag = tag;
    model_valid  = 0;
    fill_phase(tag, mode, 0, -1, rc, b);
    check("beats", 32'(b), 32'd32);
    if (exp_req > 0) check("req_cycles", 32'(rc), 32'(exp_req));
    check("blockhere", 32'(bus.BlockHere), 32'(tag));
    check("resp_memreq", 32'(bus.MemReq), 32'd0);
    check("resp_missword", bus.Instruction1i, exp_instr(bus.PC1));
    model_valid = 1;
    model_tag   = tag;
    bus.miss    = 1'b0;
    @(negedge clk);
    check("missback_pulse", 32'(bus.missback), 32'd0);
  endtask

  initial begin
    int rc, b;
    clk = 0;
    reset = 1;
    n_assert = 0;
    n_fail = 0;
    seed = $urandom;
    model_valid = 0;
    model_tag = '0;
    bus.PC1 = 32'h0000_1234;
    bus.PC2 = 32'h0000_1238;
    bus.miss = 0;
    bus.BlockTag = '0;
    bus.MemAck = 0;
    bus.MemData = '0;

    @(negedge clk);
    check("rst_memreq", 32'(bus.MemReq), 32'd0);
    check("rst_memaddr", bus.MemAddr, 32'd0);
    check("rst_missback", 32'(bus.missback), 32'd0);
    check("rst_blockhere", 32'(bus.BlockHere), 32'd0);
    check("rst_instr1", bus.Instruction1i, exp_instr(bus.PC1));
    check("rst_instr2", bus.Instruction2i, exp_instr(bus.PC2));
    reset = 0;
    rand_reads(3);

    // Cold fill of block 0 with zero-wait memory
    do_fill(10'd0, 0, 32);
    read2(32'h10, 32'h14);
    rand_reads(6);

    // Block 3, random memory timing, then reads at the block boundary
    do_fill(10'd3, 2, 0);
    read2(32'h1F8, 32'h1FC);
    read2(32'h1FC, 32'h200);
    check("next_block_missword", bus.Instruction2i, 32'h1FE0_2000);
    rand_reads(4);

    // Block 5 with memory acking every third cycle
    do_fill(10'd5, 1, 96);
    read2(32'h280, 32'h2FC);
    rand_reads(4);

    // Block 7 resident, then a hit request must not touch memory
    do_fill(10'd7, 0, 32);
    rand_reads(2);
    bus.miss = 1;
    bus.BlockTag = 10'd7;
    @(negedge clk);
    check("hit_missback", 32'(bus.missback), 32'd1);
    check("hit_blockhere", 32'(bus.BlockHere), 32'd7);
    check("hit_memreq", 32'(bus.MemReq), 32'd0);
    bus.miss = 0;
    @(negedge clk);
    check("hit_pulse", 32'(bus.missback), 32'd0);
    check("hit_memreq2", 32'(bus.MemReq), 32'd0);
    rand_reads(3);

    // Fetch flush: tag changes 5 -> 9 mid-fill; old fill completes, then block 9 is filled
    bus.miss = 1;
    bus.BlockTag = 10'd5;
    model_valid = 0;
    fill_phase(10'd5, 2, 0, 10, rc, b);
    bus.BlockTag = 10'd9;
    fill_phase(10'd5, 2, b, -1, rc, b);
    check("flush_beats", 32'(b), 32'd32);
    check("flush_blockhere", 32'(bus.BlockHere), 32'd5);
    model_valid = 1;
    model_tag = 10'd5;
    @(negedge clk);
    check("flush_pulse", 32'(bus.missback), 32'd0);
    bus.PC1 = 32'h2A0;
    bus.PC2 = 32'h480;
    #1;
    check("flush_old_instr1", bus.Instruction1i, exp_instr(32'h2A0));
    check("flush_old_instr2", bus.Instruction2i, exp_instr(32'h480));
    do_fill(10'd9, 2, 0);
    read2(32'h480, 32'h4FC);
    rand_reads(4);

    // Reset lands after the 12th word of a fill
    bus.miss = 1;
    bus.BlockTag = 10'd2;
    model_valid = 0;
    fill_phase(10'd2, 0, 0, 12, rc, b);
    @(posedge clk);
    #1;
    bus.MemAck = 0;
    reset = 1;
    #1;
    check("midrst_memreq", 32'(bus.MemReq), 32'd0);
    check("midrst_missback", 32'(bus.missback), 32'd0);
    bus.PC1 = 32'h104;
    bus.PC2 = 32'h480;
    #1;
    check("midrst_instr1", bus.Instruction1i, exp_instr(32'h104));
    check("midrst_instr2", bus.Instruction2i, exp_instr(32'h480));
    bus.miss = 0;
    @(negedge clk);
    reset = 0;
    rand_reads(3);
    do_fill(10'd2, 0, 32);
    read2(32'h100, 32'h17C);
    rand_reads(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
